// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with direct or round-robin selection.
// Optional out_parity port is enabled by defining STREAM_MUX_PARITY_EN.
module stream_mux_rr #(
    parameter int N     = 8,
    parameter int W     = 32,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_chan,
    output logic             out_valid,
`ifdef STREAM_MUX_PARITY_EN
    output logic             out_parity,
`endif
    input  logic             out_ready
);

    logic             load_en;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_found;
    logic [SEL_W-1:0] grant;
    logic             grant_ok;
    logic [N-1:0]     grant_onehot;
    logic [W-1:0]     data_sel;
    logic             xfer;

    assign load_en = !out_valid || out_ready;

    // Rotating priority scan starting at rr_ptr; rr_ptr is always < N.
    always_comb begin
        int idx;
        rr_found = 1'b0;
        rr_grant = '0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!rr_found && in_valid[idx]) begin
                rr_found = 1'b1;
                rr_grant = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        if (mode) begin
            grant    = rr_grant;
            grant_ok = rr_found;
        end else begin
            grant    = sel;
            grant_ok = ({1'b0, sel} < (SEL_W+1)'(N));
        end
    end

    always_comb begin
        grant_onehot = '0;
        data_sel     = '0;
        for (int k = 0; k < N; k++) begin
            if (grant == SEL_W'(k)) begin
                grant_onehot[k] = 1'b1;
                data_sel        = in_data[k*W +: W];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst && load_en && grant_ok) in_ready = grant_onehot;
    end

    assign xfer = |(in_ready & in_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            if (xfer) begin
                out_data  <= data_sel;
                out_chan  <= grant;
                out_valid <= 1'b1;
                if (mode) rr_ptr <= (grant == SEL_W'(N-1)) ? '0 : grant + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef STREAM_MUX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  out_parity <= 1'b0;
        else if (load_en && xfer) out_parity <= ^data_sel;
    end
`endif

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshakes on every input and on the output. It is the next-generation datapath mux for the MiniSys1A pipeline and the I/O path. Two selection modes:
- direct: an external select chooses the channel.
- round-robin: an internal fair arbiter chooses the channel.

The output is a single registered stage, so latency is 1 cycle and back-pressure propagates to the inputs.

Parameters:
- N, 8, number of input channels (2..16).
- W, 32, data width per channel in bits.
- SEL_W, 3, width of sel and out_chan; must satisfy 2**SEL_W >= N.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*W  flattened channel data; channel k occupies bits [k*W+W-1 : k*W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational from state and inputs.
- mode  input  1  0 = direct select, 1 = round-robin.
- sel  input  SEL_W  channel index used in direct mode.
- out_data  output  W  registered data.
- out_chan  output  SEL_W  registered index of the channel that produced out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset values (async on rst high): out_data = 0, out_chan = 0, out_valid = 0, rr_ptr = 0. in_ready is all-zero while rst is high.
- Register load: load_en = !out_valid | out_ready. A transfer occurs on an input channel when its in_valid and in_ready are both 1. An output transfer occurs when out_valid and out_ready are both 1.
- Grant in direct mode (mode = 0):
  - grant = sel.
  - in_ready[sel] = load_en; all other bits of in_ready are 0.
  - If sel >= N, no channel is granted: all in_ready = 0 and no load.
- Grant in round-robin mode (mode = 1):
  - grant = the first k with in_valid[k] = 1, scanning rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1 (modulo N).
  - in_ready[grant] = load_en; all other bits are 0.
  - If no in_valid bit is set, all in_ready = 0.
- Capture and drain:
  - On any input transfer: out_data <= channel data, out_chan <= grant, out_valid <= 1.
  - In round-robin mode, rr_ptr also updates to (grant+1) mod N; the wrap from N-1 goes to 0.
  - If load_en = 1 and no input transfer occurs: out_valid <= 0, out_data and out_chan hold.
  - If load_en = 0: out_data, out_chan and out_valid hold, and all in_ready = 0.
- Throughput: one word per cycle when out_ready is held at 1. Drain and refill happen in the same cycle with no bubble.
- Latency: an input transfer at edge t gives out_valid = 1 with that data from edge t onwards.
- Stability: while out_valid = 1 and out_ready = 0, out_data and out_chan must not change.
- Mode and sel may change on any cycle and take effect on that cycle's grant. rr_ptr is only updated by round-robin transfers and keeps its value in direct mode.
- Reset mid-operation: a word pending in the output register is dropped (out_valid = 0 immediately). Any input transfer in progress in that cycle is not accepted.

Optional Feature:
Macro STREAM_MUX_PARITY_EN.
- Defined: adds output out_parity (1 bit), the registered even parity of the captured word (XOR of the W data bits). It loads and holds exactly like out_data and resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset and idle: assert rst mid-cycle with out_valid = 1 -> out_valid drops to 0 asynchronously; after release with all in_valid = 0, out_valid stays 0 and in_ready = 0.
- Direct streaming: mode = 0, sel = 5, in_valid = 8'hFF, ch5 = 32'hA5A5_0005, out_ready = 1 -> in_ready = 8'b0010_0000; one cycle later out_data = 32'hA5A5_0005, out_chan = 5; one word per cycle.
- Direct with sel out of range: N = 6, sel = 7 -> in_ready = 0 and out_valid falls to 0 after draining.
- Round-robin fairness: mode = 1, all 8 channels valid, out_ready = 1 -> out_chan sequence 0,1,…,7,0; with in_valid = 8'b1000_0100 the sequence alternates 2,7,2,7.
- Back-pressure: out_valid = 1, out_ready = 0 for 4 cycles -> in_ready = 0, out_data stable; the first cycle out_ready = 1 drains and loads the next word with no bubble.
- Parity (macro defined): capture 32'h0000_0007 -> out_parity = 1; capture 32'h0000_0003 -> out_parity = 0.
